// File: rtl/demux_seq_pkg.sv
// rtl/demux_seq_pkg.sv - shared types and widths for the demux sequencer
// Channel count, state encoding and counter helpers used by demux_sequencer.
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_sequencer_rr_next_channel.sv
// rtl/demux_sequencer_rr_next_channel.sv - round-robin grant over enabled channels
// Picks the first enabled channel after last_sel, wrapping 3->0.
module rr_next_channel
  import demux_seq_pkg::*;
(
  input  logic [CH_W-1:0]   last_sel,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [CH_W-1:0]   grant,
  output logic              any_en
);

  logic [CH_W-1:0] cand;
  logic            found;

  always_comb begin
    grant = last_sel;
    cand  = last_sel;
    found = 1'b0;
    // Offset 4 truncates to 0, so last_sel itself is tried last.
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = last_sel + CH_W'(i);
      if (!found && ch_enable[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign any_en = |ch_enable;

endmodule

// File: rtl/demux_sequencer.sv
// rtl/demux_sequencer.sv - round-robin feeder driving a 4-channel demux data/sel
// Optional per-channel delivery counters enabled by macro DEMUX_SEQ_COUNT_EN.
module demux_sequencer
  import demux_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_CH-1:0]     ch_enable,
  output logic [WIDTH-1:0]      data,
  output logic [CH_W-1:0]       sel,
  output logic                  active,
  output logic [NUM_CH*CNT_W-1:0] ch_count
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CH_W-1:0]  sel_nxt;
  logic [CH_W-1:0]  last_sel, last_sel_nxt;
  logic [CH_W-1:0]  grant;
  logic             any_en;
  logic             xfer;

  rr_next_channel u_rr (
    .last_sel  (last_sel),
    .ch_enable (ch_enable),
    .grant     (grant),
    .any_en    (any_en)
  );

  assign in_ready = any_en && ((state == IDLE) || (cnt == '0));
  assign xfer     = in_valid && in_ready;
  assign active   = (state == HOLD);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    data_nxt     = data;
    sel_nxt      = sel;
    last_sel_nxt = last_sel;
    if (xfer) begin
      state_nxt    = HOLD;
      cnt_nxt      = RELOAD;
      data_nxt     = in_data;
      sel_nxt      = grant;
      last_sel_nxt = grant;
    end else if (state == HOLD) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        // Idle drives zero so every demux output reads 0; sel keeps its value.
        state_nxt = IDLE;
        data_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data     <= '0;
      sel      <= '0;
      last_sel <= 2'b11;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data     <= data_nxt;
      sel      <= sel_nxt;
      last_sel <= last_sel_nxt;
    end
  end

`ifdef DEMUX_SEQ_COUNT_EN
  logic [CNT_W-1:0] dcnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_CH; n++) dcnt[n] <= '0;
    end else if (xfer) begin
      dcnt[grant] <= sat_inc(dcnt[grant]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign ch_count[g*CNT_W +: CNT_W] = dcnt[g];
  end
`else
  assign ch_count = '0;
`endif

endmodule

// File: tb/tb_demux_sequencer.sv
// tb/tb_demux_sequencer.sv - self-checking bench for demux_sequencer
// Directed plan steps plus random traffic against a remaining-cycles delivery model.
module tb_demux_sequencer;

  localparam int WIDTH = 4;
  localparam int DWELL = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ch_enable;
  logic [3:0]  data;
  logic [1:0]  sel;
  logic        active;
  logic [31:0] ch_count;

  int checks = 0;
  int errors = 0;

  // Model: words still to be shown (including the current cycle), word, channel.
  int         m_rem;
  logic [3:0] m_data;
  int         m_sel;
  int         m_last;
  int         m_cnt [4];
  bit         m_ready;
  bit         m_acc;

  demux_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ch_enable (ch_enable),
    .data      (data),
    .sel       (sel),
    .active    (active),
    .ch_count  (ch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_grant(input int last, input logic [3:0] en);
    for (int k = 1; k <= 4; k++) begin
      if (en[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  function automatic logic [31:0] exp_counts();
    logic [31:0] v = '0;
`ifdef DEMUX_SEQ_COUNT_EN
    for (int i = 0; i < 4; i++) v[8*i +: 8] = m_cnt[i][7:0];
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_data = 4'h0; m_sel = 0; m_last = 3; m_acc = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Drive one cycle: inputs after the edge, outputs checked mid-cycle, model stepped at the edge.
  task automatic cyc(input logic rst, input logic v, input logic [3:0] d, input logic [3:0] en);
    int g;
    reset_n = rst; in_valid = v; in_data = d; ch_enable = en;
    m_ready = (en != 4'h0) && (m_rem <= 1);
    #3;
    check("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
    check("data",     {28'b0, data},     {28'b0, m_data});
    check("sel",      {30'b0, sel},      32'(m_sel));
    check("active",   {31'b0, active},   {31'b0, (m_rem > 0)});
    check("ch_count", ch_count,          exp_counts());
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (v && m_ready) begin
      g = rr_grant(m_last, en);
      m_rem = DWELL; m_data = d; m_sel = g; m_last = g; m_acc = 1;
      if (m_cnt[g] < 255) m_cnt[g]++;
    end else begin
      m_acc = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_data = 4'h0;
      end
    end
    #1;
  endtask

  task automatic send(input logic [3:0] w, input logic [3:0] en, input logic [1:0] exp_sel, input string tag);
    int n = 0;
    do begin
      cyc(1'b1, 1'b1, w, en);
      n++;
    end while (!m_acc && n < 8);
    check({tag, "_accepted"}, {31'b0, m_acc}, 32'd1);
    check({tag, "_sel"}, {30'b0, sel}, {30'b0, exp_sel});
    check({tag, "_data"}, {28'b0, data}, {28'b0, w});
  endtask

  initial begin
    logic [3:0] rr_words;
    model_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; ch_enable = 4'hF;
    #1;

    // Reset then idle.
    cyc(1'b0, 1'b0, 4'h0, 4'hF);
    cyc(1'b0, 1'b0, 4'h0, 4'hF);
    cyc(1'b1, 1'b0, 4'h0, 4'hF);
    check("idle_data", {28'b0, data}, 32'd0);
    check("idle_sel", {30'b0, sel}, 32'd0);
    check("idle_active", {31'b0, active}, 32'd0);
    check("idle_ready", {31'b0, in_ready}, 32'd1);

    // Round-robin over all channels, back-to-back.
    send(4'h5, 4'hF, 2'd0, "rr0");
    send(4'hA, 4'hF, 2'd1, "rr1");
    send(4'h3, 4'hF, 2'd2, "rr2");
    send(4'hC, 4'hF, 2'd3, "rr3");
    send(4'h7, 4'hF, 2'd0, "rr4");
    rr_words = 4'h0;
    check("rr_no_bubble_active", {31'b0, active}, 32'd1);

    // Masked channels, then all channels disabled.
    send(4'h1, 4'b1010, 2'd1, "mask0");
    send(4'h2, 4'b1010, 2'd3, "mask1");
    send(4'h3, 4'b1010, 2'd1, "mask2");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 4'hE, 4'h0);
    check("dis_ready", {31'b0, in_ready}, 32'd0);
    check("dis_data", {28'b0, data}, {28'b0, rr_words});

    // Mask change mid-hold keeps the current delivery.
    send(4'h9, 4'b0001, 2'd0, "midmask");
    cyc(1'b1, 1'b0, 4'h0, 4'b0100);
    check("midmask_hold_data", {28'b0, data}, 32'h9);
    check("midmask_hold_sel", {30'b0, sel}, 32'd0);
    cyc(1'b1, 1'b0, 4'h0, 4'b0100);
    check("midmask_hold_data2", {28'b0, data}, 32'h9);
    send(4'h4, 4'b0100, 2'd2, "midmask_next");

    // Reset in the second hold cycle of 0xF.
    send(4'hF, 4'hF, 2'd3, "rst_word");
    cyc(1'b1, 1'b0, 4'h0, 4'hF);
    cyc(1'b0, 1'b0, 4'h0, 4'hF);
    check("rst_data", {28'b0, data}, 32'd0);
    check("rst_active", {31'b0, active}, 32'd0);
    send(4'h6, 4'hF, 2'd0, "rst_next");

    // Counter saturation on channel 0.
    for (int i = 0; i < 300; i++) send(4'($urandom), 4'b0001, 2'd0, "cnt");
    cyc(1'b1, 1'b0, 4'h0, 4'b0001);
`ifdef DEMUX_SEQ_COUNT_EN
    check("cnt_sat", ch_count, 32'h0000_00FF);
`else
    check("cnt_off", ch_count, 32'h0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), 1'($urandom), 4'($urandom),
          ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
